// File: rtl/exc_sequencer.sv
// Exception/interrupt/eret sequencer at the M stage. It drives the CP0 update, the pipeline flush and the fetch redirect.
// Latency: kill_m is combinational. ENTER/RETURN pulses appear one cycle after detection. busy lasts 1+FLUSH_CYCLES cycles.
// Backpressure: requests are sampled only in IDLE. While busy, all requests are ignored; a pending interrupt waits for a valid M instruction.
module exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_m,
    input  logic [31:0]      pc_m,
    input  logic             bd_m,
    input  logic [4:0]       exc_code_m,
    input  logic             eret_m,
    input  logic [5:0]       hwint,
    input  logic [5:0]       sr_im,
    input  logic             sr_ie,
    input  logic             sr_exl,
    input  logic [31:0]      epc_in,
    output logic             kill_m,
    output logic             cp0_exl_set,
    output logic [4:0]       cp0_exccode,
    output logic [31:0]      cp0_epc,
    output logic             cp0_bd,
    output logic             cp0_exl_clr,
    output logic             flush,
    output logic             stall_f,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] exc_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTER  = 2'd1,
        S_RETURN = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    // DRAIN counts down to zero, so loading FLUSH_CYCLES-1 gives FLUSH_CYCLES drain cycles
    localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    logic        is_idle;
    logic        int_req;
    logic        exc_req;
    logic        ret_req;
    logic        take;
    logic [31:0] epc_calc;

    assign is_idle = (state == S_IDLE);
    assign int_req = valid_m & ~sr_exl & sr_ie & (|(hwint & sr_im));
    assign exc_req = valid_m & ~sr_exl & (exc_code_m != 5'd0);
    assign ret_req = valid_m & sr_exl & eret_m;
    assign take    = is_idle & (int_req | exc_req);
    assign kill_m  = take;

    // A delay-slot instruction restarts at its branch, one word earlier; the address wraps at 32 bits
    assign epc_calc = {pc_m[31:2], 2'b00} - (bd_m ? 32'd4 : 32'd0);

    // Next-state and drain-counter decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (take) begin
                    state_nxt = S_ENTER;
                end else if (ret_req) begin
                    state_nxt = S_RETURN;
                end
            end
            S_ENTER, S_RETURN: begin
                state_nxt = S_DRAIN;
                cnt_nxt   = DRAIN_INIT;
            end
            S_DRAIN: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight sequence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered control outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cp0_exl_set <= 1'b0;
            cp0_exl_clr <= 1'b0;
            redirect    <= 1'b0;
            flush       <= 1'b0;
            stall_f     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cp0_exl_set <= (state_nxt == S_ENTER);
            cp0_exl_clr <= (state_nxt == S_RETURN);
            redirect    <= (state_nxt == S_ENTER) || (state_nxt == S_RETURN);
            flush       <= (state_nxt != S_IDLE);
            stall_f     <= (state_nxt != S_IDLE);
            busy        <= (state_nxt != S_IDLE);
        end
    end

    // CP0 payload and redirect target are captured at detection and hold until the next event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cp0_exccode <= 5'd0;
            cp0_epc     <= 32'd0;
            cp0_bd      <= 1'b0;
            redirect_pc <= 32'd0;
        end else if (take) begin
            cp0_exccode <= int_req ? 5'd0 : exc_code_m;
            cp0_epc     <= epc_calc;
            cp0_bd      <= bd_m;
            redirect_pc <= HANDLER_ADDR;
        end else if (is_idle && ret_req) begin
            redirect_pc <= epc_in;
        end
    end

    // Saturating count of exception/interrupt entries, bumped during ENTER
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_count <= '0;
        end else if ((state == S_ENTER) && (exc_count != {CNT_W{1'b1}})) begin
            exc_count <= exc_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer. Two instances share the stimulus: the default one and a 2-bit-counter one for saturation.
// Latency: expected ENTER/RETURN payloads are queued at detection and popped by a monitor on each redirect pulse.
// Backpressure: the stimulus waits out each busy window, bounded by a cycle budget, before issuing the next vector.
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic        eret_m;
    logic [5:0]  hwint;
    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        sr_exl;
    logic [31:0] epc_in;

    logic        kill_m, cp0_exl_set, cp0_bd, cp0_exl_clr, flush, stall_f, redirect, busy;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_epc, redirect_pc;
    logic [15:0] exc_count;

    logic        kill_m_s, cp0_exl_set_s, cp0_bd_s, cp0_exl_clr_s, flush_s, stall_f_s, redirect_s, busy_s;
    logic [4:0]  cp0_exccode_s;
    logic [31:0] cp0_epc_s, redirect_pc_s;
    logic [1:0]  exc_count_s;

    always #5 clk = ~clk;

    exc_sequencer dut (
        .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
        .exc_code_m(exc_code_m), .eret_m(eret_m), .hwint(hwint), .sr_im(sr_im),
        .sr_ie(sr_ie), .sr_exl(sr_exl), .epc_in(epc_in), .kill_m(kill_m),
        .cp0_exl_set(cp0_exl_set), .cp0_exccode(cp0_exccode), .cp0_epc(cp0_epc),
        .cp0_bd(cp0_bd), .cp0_exl_clr(cp0_exl_clr), .flush(flush), .stall_f(stall_f),
        .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy), .exc_count(exc_count)
    );

    exc_sequencer #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
        .exc_code_m(exc_code_m), .eret_m(eret_m), .hwint(hwint), .sr_im(sr_im),
        .sr_ie(sr_ie), .sr_exl(sr_exl), .epc_in(epc_in), .kill_m(kill_m_s),
        .cp0_exl_set(cp0_exl_set_s), .cp0_exccode(cp0_exccode_s), .cp0_epc(cp0_epc_s),
        .cp0_bd(cp0_bd_s), .cp0_exl_clr(cp0_exl_clr_s), .flush(flush_s), .stall_f(stall_f_s),
        .redirect(redirect_s), .redirect_pc(redirect_pc_s), .busy(busy_s), .exc_count(exc_count_s)
    );

    typedef struct {
        logic        set;
        logic        clr;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic set, input logic clr, input logic [4:0] code,
                        input logic [31:0] epc, input logic bd, input logic [31:0] rpc);
        exp_t e;
        e.set = set; e.clr = clr; e.code = code; e.epc = epc; e.bd = bd; e.rpc = rpc;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        valid_m = 1'b0; pc_m = 32'd0; bd_m = 1'b0; exc_code_m = 5'd0; eret_m = 1'b0;
        hwint = 6'd0; sr_im = 6'd0; sr_ie = 1'b0; sr_exl = 1'b0; epc_in = 32'd0;
    endtask

    // Called just after the detection cycle's inputs are applied; returns at an IDLE negedge
    task automatic finish_event(input int cnt_big, input int cnt_small);
        int n;
        n = 0;
        @(negedge clk);
        idle_inputs();
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("busy_window", n, 3);
        chk("exc_count", exc_count, cnt_big);
        chk("exc_count_sat", exc_count_s, cnt_small);
    endtask

    // Scoreboard monitor: every redirect pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset === 1'b1 && redirect === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_redirect", {31'd0, redirect}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cp0_exl_set", {31'd0, cp0_exl_set}, {31'd0, e.set});
                chk("cp0_exl_clr", {31'd0, cp0_exl_clr}, {31'd0, e.clr});
                chk("cp0_exccode", {27'd0, cp0_exccode}, {27'd0, e.code});
                chk("cp0_epc", cp0_epc, e.epc);
                chk("cp0_bd", {31'd0, cp0_bd}, {31'd0, e.bd});
                chk("redirect_pc", redirect_pc, e.rpc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_stall_f", {31'd0, stall_f}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_exl_set", {31'd0, cp0_exl_set}, 32'd0);
        chk("rst_exl_clr", {31'd0, cp0_exl_clr}, 32'd0);
        chk("rst_kill_m", {31'd0, kill_m}, 32'd0);
        chk("rst_exc_count", exc_count, 32'd0);
        chk("rst_cp0_epc", cp0_epc, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_exccode", {27'd0, cp0_exccode}, 32'd0);
        chk("rst_cp0_bd", {31'd0, cp0_bd}, 32'd0);

        // plain exception
        valid_m = 1'b1; pc_m = 32'h3008; exc_code_m = 5'd4;
        #1 chk("kill_exc", {31'd0, kill_m}, 32'd1);
        push(1'b1, 1'b0, 5'd4, 32'h3008, 1'b0, 32'h4180);
        finish_event(1, 1);

        // interrupt beats simultaneous exception, delay-slot EPC
        valid_m = 1'b1; pc_m = 32'h3010; bd_m = 1'b1; exc_code_m = 5'd10;
        hwint = 6'b000100; sr_im = 6'b000100; sr_ie = 1'b1;
        #1 chk("kill_int", {31'd0, kill_m}, 32'd1);
        push(1'b1, 1'b0, 5'd0, 32'h300C, 1'b1, 32'h4180);
        finish_event(2, 2);

        // eret: cp0 payload holds previous values, count unchanged
        valid_m = 1'b1; sr_exl = 1'b1; eret_m = 1'b1; epc_in = 32'h3020; exc_code_m = 5'd4;
        #1 chk("kill_eret", {31'd0, kill_m}, 32'd0);
        push(1'b0, 1'b1, 5'd0, 32'h300C, 1'b1, 32'h3020);
        finish_event(2, 2);

        // conditions that must not take: EXL set, IE clear, masked line
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            valid_m = 1'b1;
            case (i)
                0: begin sr_exl = 1'b1; exc_code_m = 5'd4; hwint = 6'h3F; sr_im = 6'h3F; sr_ie = 1'b1; end
                1: begin hwint = 6'b000001; sr_im = 6'b000001; sr_ie = 1'b0; end
                default: begin hwint = 6'b100000; sr_im = 6'b011111; sr_ie = 1'b1; end
            endcase
            #1 chk("kill_none", {31'd0, kill_m}, 32'd0);
            @(negedge clk);
            chk("busy_none", {31'd0, busy}, 32'd0);
        end
        idle_inputs();
        @(negedge clk);

        // pending interrupt waits for a valid instruction
        hwint = 6'b000100; sr_im = 6'b000100; sr_ie = 1'b1; valid_m = 1'b0; pc_m = 32'h3100;
        for (int i = 0; i < 3; i++) begin
            #1 chk("kill_bubble", {31'd0, kill_m}, 32'd0);
            @(negedge clk);
            chk("busy_bubble", {31'd0, busy}, 32'd0);
        end
        valid_m = 1'b1;
        #1 chk("kill_pending", {31'd0, kill_m}, 32'd1);
        push(1'b1, 1'b0, 5'd0, 32'h3100, 1'b0, 32'h4180);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        // exception arriving during DRAIN is ignored
        valid_m = 1'b1; pc_m = 32'h3200; exc_code_m = 5'd8;
        #1 chk("kill_drain", {31'd0, kill_m}, 32'd0);
        @(negedge clk);
        idle_inputs();
        chk("busy_drain2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("count_after_pending", exc_count, 32'd3);
        chk("count_s_after_pending", exc_count_s, 32'd3);

        // EPC wrap below zero; small counter saturates
        valid_m = 1'b1; pc_m = 32'h0000_0002; bd_m = 1'b1; exc_code_m = 5'd12;
        #1 chk("kill_wrap", {31'd0, kill_m}, 32'd1);
        push(1'b1, 1'b0, 5'd12, 32'hFFFF_FFFC, 1'b1, 32'h4180);
        finish_event(4, 3);

        // unaligned PC low bits are cleared
        valid_m = 1'b1; pc_m = 32'h3013; exc_code_m = 5'd5;
        #1 chk("kill_align", {31'd0, kill_m}, 32'd1);
        push(1'b1, 1'b0, 5'd5, 32'h3010, 1'b0, 32'h4180);
        finish_event(5, 3);

        // reset during DRAIN aborts immediately
        valid_m = 1'b1; pc_m = 32'h3400; exc_code_m = 5'd4;
        #1 chk("kill_prereset", {31'd0, kill_m}, 32'd1);
        push(1'b1, 1'b0, 5'd4, 32'h3400, 1'b0, 32'h4180);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_stall_f", {31'd0, stall_f}, 32'd0);
        chk("midrst_flush", {31'd0, flush}, 32'd0);
        chk("midrst_count", exc_count, 32'd0);
        chk("midrst_count_s", exc_count_s, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("postrst_busy", {31'd0, busy}, 32'd0);

        // recovery after reset
        valid_m = 1'b1; pc_m = 32'h3500; exc_code_m = 5'd6;
        #1 chk("kill_recover", {31'd0, kill_m}, 32'd1);
        push(1'b1, 1'b0, 5'd6, 32'h3500, 1'b0, 32'h4180);
        finish_event(1, 1);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
